brownout_ctrl: RTL and testbench
================================

# brownout_ctrl

Sequencing and event-reporting controller for the brownout detector's digital core. It powers the detector up and holds off monitoring until the analog path has settled. It applies trip-threshold changes safely by masking events while the comparators re-settle. It turns the detector's power-good output into a counted, acknowledged interrupt. The block sits between the configuration registers and the detector's `ena`, `vtrip`, `otrip` and `force_short_oneshot` inputs, and runs on the detector's `osc_ck`.

## Interface
- `SETTLE_CYCLES`, default 64: osc_ck cycles of masking after enable or threshold change; minimum 2.
- `EVT_W`, default 8: width of the brownout event counter.

Ports:
- `osc_ck` in 1: block clock, same RC oscillator clock as the detector.
- `rsb` in 1: reset; one clock, asynchronous assert, active-low.
- `cfg_ena` in 1: software enable of brownout monitoring.
- `cfg_vtrip` in 3: requested vtrip code.
- `cfg_otrip` in 3: requested otrip code.
- `cfg_fast` in 1: request shortened one-shot (test mode).
- `evt_clr` in 1: single-cycle pulse that clears the event counter.
- `irq_ack` in 1: single-cycle pulse that acknowledges the interrupt.
- `bo_pgood` in 1: detector one-shot output; 1 means supply good, 0 means brownout or holdoff. Asynchronous to this block.
- `bo_ena` out 1: detector enable.
- `bo_vtrip` out 3: applied vtrip code.
- `bo_otrip` out 3: applied otrip code.
- `bo_force_short` out 1: detector force_short_oneshot.
- `armed` out 1: monitoring active and events unmasked.
- `irq` out 1: level interrupt, brownout event pending.
- `evt_cnt` out EVT_W: saturating count of brownout events.

## Operation
- `bo_pgood` is passed through a 2-flop synchronizer, giving `pg_s`. All decisions use `pg_s`.
- FSM states: OFF, STARTUP, ARMED, TRIPPED, RETUNE.
- **OFF**
  - `bo_ena`=0; `bo_vtrip`/`bo_otrip` track the cfg inputs every cycle.
  - `cfg_ena`=1 moves to STARTUP, loads the settle counter with SETTLE_CYCLES-1 and sets `bo_ena`=1.
- **STARTUP**
  - Settle counter decrements each cycle.
  - Moves to ARMED when the counter is 0 and `pg_s`=1.
  - If `pg_s`=0 at counter 0, the FSM waits in STARTUP with the counter held at 0; no event is recorded.
- **ARMED**
  - `armed`=1.
  - `pg_s`=0 moves to TRIPPED. On the same edge: `irq` is set and `evt_cnt` increments, saturating at all-ones.
  - Otherwise, if the cfg thresholds differ from the applied thresholds, moves to RETUNE. On the same edge the new codes are latched onto `bo_vtrip`/`bo_otrip` and the counter is reloaded.
  - A brownout has priority over a retune request in the same cycle.
- **TRIPPED**
  - `armed`=0.
  - Returns to ARMED when `pg_s`=1.
  - Threshold changes are deferred and are taken from ARMED afterwards.
- **RETUNE**
  - `armed`=0; events are masked.
  - Counts down like STARTUP; exits to ARMED under the same condition (counter 0 and `pg_s`=1).
- **Disable:** `cfg_ena`=0 in any state moves to OFF on the next edge and sets `bo_ena`=0. `irq` and `evt_cnt` are retained.
- **irq:** set by an event, cleared by `irq_ack`. If set and ack occur in the same cycle, set wins.
- **evt_cnt:** cleared by `evt_clr`. If increment and clear occur in the same cycle, the result is 1.
- **bo_force_short:** `cfg_fast` registered.

## Timing
- Reset values:
  - State OFF.
  - `bo_ena`=0, `bo_vtrip`=`bo_otrip`=3'b000, `bo_force_short`=0.
  - `armed`=0, `irq`=0, `evt_cnt`=0.
  - Synchronizer flops reset to 0.
- All outputs are registered; no combinational input-to-output paths.
- Enable: `bo_ena` rises 1 edge after `cfg_ena` is sampled high. `armed` rises SETTLE_CYCLES edges after `bo_ena`, provided `pg_s`=1.
- Event latency: `irq` and `evt_cnt` update on the 3rd osc_ck edge after `bo_pgood` falls (2 synchronizer edges + 1 FSM edge).
- A `bo_pgood` low pulse shorter than 2 cycles may be missed; this is acceptable because the detector's one-shot guarantees multi-cycle lows.
- Retune: applied codes change 1 edge after a mismatch is seen in ARMED. `armed` is low for SETTLE_CYCLES cycles minimum.
- Reset mid-operation: all state returns to reset values immediately and asynchronously.

## Structure
- Package `brownout_pkg`:
  - FSM state enum `bo_state_t`.
  - Trip-code width constant `TRIP_W`=3.
  - Default `SETTLE_CYCLES`.
- Sub-module `brownout_sync2`: generic 2-flop synchronizer with async active-low reset; used for `bo_pgood`.
- Settle counter width: `$clog2(SETTLE_CYCLES)`.

## Test plan
- **Enable, no brownout:** reset, `cfg_ena`=1, `bo_pgood`=1, SETTLE_CYCLES=64 -> `bo_ena`=1 after 1 edge; `armed`=1 exactly 64 edges later; `irq`=0, `evt_cnt`=0.
- **Single brownout:** from ARMED, drive `bo_pgood`=0 for 10 cycles, then 1 -> `irq`=1 and `evt_cnt`=1 on the 3rd edge after the fall; `armed` returns high 3 edges after the rise; `irq_ack` pulse clears `irq`.
- **Retune masks events:** from ARMED, change `cfg_vtrip` 3'b010->3'b101 while pulsing `bo_pgood` low for 5 cycles during the settle window -> `bo_vtrip`=3'b101 after 1 edge; no `irq`; `evt_cnt` unchanged. If `pg_s` is 0 when the counter reaches 0, RETUNE is held until `pg_s`=1.
- **Saturation and clear:** EVT_W=2; 5 brownout events -> `evt_cnt`=3; `evt_clr` coincident with a 6th event -> `evt_cnt`=1.
- **irq ack collision:** `irq_ack` on the same edge as a new event -> `irq` stays 1.
- **Disable and async reset mid-TRIPPED:** `cfg_ena`=0 -> OFF, `bo_ena`=0 next edge, `evt_cnt` retained; assert `rsb` mid-RETUNE -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/brownout_pkg.sv
// ---------------------------------------------------------------------------
// brownout_pkg
// Shared types and constants for the brownout detector sequencing controller.
//   bo_state_t        : controller FSM state encoding
//   TRIP_W            : width of the vtrip / otrip threshold codes
//   SETTLE_CYCLES_DEF : default number of osc_ck cycles the analog path needs
//                       to settle after enable or a threshold change
// ---------------------------------------------------------------------------
package brownout_pkg;

  localparam int TRIP_W            = 3;
  localparam int SETTLE_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STARTUP = 3'd1,
    ST_ARMED   = 3'd2,
    ST_TRIPPED = 3'd3,
    ST_RETUNE  = 3'd4
  } bo_state_t;

endpackage : brownout_pkg

// File: rtl/brownout_sync2.sv
// ---------------------------------------------------------------------------
// brownout_sync2
// Generic two-flop synchronizer for a single asynchronous level.
//   clk   in  : destination clock
//   rst_n in  : asynchronous active-low reset (both flops clear to 0)
//   d     in  : asynchronous input level
//   q     out : synchronized level, two clk edges of latency
// ---------------------------------------------------------------------------
module brownout_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : brownout_sync2

// File: rtl/brownout_ctrl.sv
// ---------------------------------------------------------------------------
// brownout_ctrl
// Power-up sequencing, safe threshold retuning and event reporting for the
// brownout detector digital core. Runs on the detector's osc_ck.
//   osc_ck         in  : block clock (detector RC oscillator)
//   rsb            in  : asynchronous active-low reset
//   cfg_ena        in  : software enable of monitoring
//   cfg_vtrip      in  : requested vtrip code
//   cfg_otrip      in  : requested otrip code
//   cfg_fast       in  : request shortened one-shot (test mode)
//   evt_clr        in  : pulse, clears the event counter
//   irq_ack        in  : pulse, acknowledges the interrupt
//   bo_pgood       in  : detector power-good (asynchronous)
//   bo_ena         out : detector enable
//   bo_vtrip       out : applied vtrip code
//   bo_otrip       out : applied otrip code
//   bo_force_short out : detector force_short_oneshot
//   armed          out : monitoring active and events unmasked
//   irq            out : level interrupt, brownout event pending
//   evt_cnt        out : saturating brownout event count
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module brownout_ctrl
  import brownout_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int EVT_W         = 8
) (
  input  logic              osc_ck,
  input  logic              rsb,
  input  logic              cfg_ena,
  input  logic [TRIP_W-1:0] cfg_vtrip,
  input  logic [TRIP_W-1:0] cfg_otrip,
  input  logic              cfg_fast,
  input  logic              evt_clr,
  input  logic              irq_ack,
  input  logic              bo_pgood,
  output logic              bo_ena,
  output logic [TRIP_W-1:0] bo_vtrip,
  output logic [TRIP_W-1:0] bo_otrip,
  output logic              bo_force_short,
  output logic              armed,
  output logic              irq,
  output logic [EVT_W-1:0]  evt_cnt
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [EVT_W-1:0] EVT_ONE    = EVT_W'(1);
  localparam logic [EVT_W-1:0] EVT_ZERO   = EVT_W'(0);
  localparam logic [EVT_W-1:0] EVT_MAX    = {EVT_W{1'b1}};

  bo_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bo_ena_q, bo_ena_d;
  logic [TRIP_W-1:0] vtrip_q, vtrip_d;
  logic [TRIP_W-1:0] otrip_q, otrip_d;
  logic              force_short_q, force_short_d;
  logic              armed_q, armed_d;
  logic              irq_q, irq_d;
  logic [EVT_W-1:0]  evt_q, evt_d;

  logic pg_s;
  logic settle_done_s;
  logic thr_mismatch_s;
  logic event_s;
  logic retune_s;
  logic start_s;

  brownout_sync2 u_pg_sync (
    .clk   (osc_ck),
    .rst_n (rsb),
    .d     (bo_pgood),
    .q     (pg_s)
  );

  // Settle window is over only once the counter has drained and power is good;
  // otherwise the FSM parks with the counter at zero.
  assign settle_done_s  = (cnt_q == CNT_ZERO) && pg_s;
  assign thr_mismatch_s = (cfg_vtrip != vtrip_q) || (cfg_otrip != otrip_q);

  // State register.
  always_ff @(posedge osc_ck or negedge rsb) begin
    if (!rsb) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; disable overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (!cfg_ena) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_STARTUP;
        end
        ST_STARTUP, ST_RETUNE: begin
          if (settle_done_s) begin
            state_d = ST_ARMED;
          end else begin
            state_d = state_q;
          end
        end
        ST_ARMED: begin
          // Brownout wins over a pending retune request.
          if (!pg_s) begin
            state_d = ST_TRIPPED;
          end else if (thr_mismatch_s) begin
            state_d = ST_RETUNE;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_TRIPPED: begin
          if (pg_s) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_TRIPPED;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // Transition qualifiers derived from the current and next state.
  assign event_s  = (state_q == ST_ARMED)  && (state_d == ST_TRIPPED);
  assign retune_s = (state_q == ST_ARMED)  && (state_d == ST_RETUNE);
  assign start_s  = (state_q == ST_OFF)    && (state_d == ST_STARTUP);

  // Output and datapath next values, all captured into flops below.
  always_comb begin
    bo_ena_d      = (state_d != ST_OFF);
    armed_d       = (state_d == ST_ARMED);
    force_short_d = cfg_fast;

    // Settle counter: reload on entry to a settle window, drain inside it.
    if (start_s || retune_s) begin
      cnt_d = CNT_RELOAD;
    end else if (((state_q == ST_STARTUP) || (state_q == ST_RETUNE)) &&
                 (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // Thresholds follow cfg while off, and are otherwise only replaced on a
    // retune so the comparators never see a change outside a masked window.
    if ((state_q == ST_OFF) || retune_s) begin
      vtrip_d = cfg_vtrip;
      otrip_d = cfg_otrip;
    end else begin
      vtrip_d = vtrip_q;
      otrip_d = otrip_q;
    end

    // New event takes precedence over acknowledge.
    if (event_s) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    // Clear coincident with an event leaves that one event counted.
    if (evt_clr) begin
      if (event_s) begin
        evt_d = EVT_ONE;
      end else begin
        evt_d = EVT_ZERO;
      end
    end else if (event_s && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_ONE;
    end else begin
      evt_d = evt_q;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge osc_ck or negedge rsb) begin
    if (!rsb) begin
      cnt_q         <= CNT_ZERO;
      bo_ena_q      <= 1'b0;
      vtrip_q       <= {TRIP_W{1'b0}};
      otrip_q       <= {TRIP_W{1'b0}};
      force_short_q <= 1'b0;
      armed_q       <= 1'b0;
      irq_q         <= 1'b0;
      evt_q         <= EVT_ZERO;
    end else begin
      cnt_q         <= cnt_d;
      bo_ena_q      <= bo_ena_d;
      vtrip_q       <= vtrip_d;
      otrip_q       <= otrip_d;
      force_short_q <= force_short_d;
      armed_q       <= armed_d;
      irq_q         <= irq_d;
      evt_q         <= evt_d;
    end
  end

  assign bo_ena         = bo_ena_q;
  assign bo_vtrip       = vtrip_q;
  assign bo_otrip       = otrip_q;
  assign bo_force_short = force_short_q;
  assign armed          = armed_q;
  assign irq            = irq_q;
  assign evt_cnt        = evt_q;

endmodule : brownout_ctrl

// File: tb/tb_brownout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_brownout_ctrl
// Directed bench for brownout_ctrl (SETTLE_CYCLES=64, EVT_W=2). Stimulus
// pushes expected output values tagged with the osc_ck edge number at which
// they must hold; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_brownout_ctrl;

  localparam int SC = 64;
  localparam int EW = 2;

  localparam int S_ENA   = 0;
  localparam int S_VTRIP = 1;
  localparam int S_OTRIP = 2;
  localparam int S_FAST  = 3;
  localparam int S_ARMED = 4;
  localparam int S_IRQ   = 5;
  localparam int S_EVT   = 6;

  logic          osc_ck = 1'b0;
  logic          rsb;
  logic          cfg_ena;
  logic [2:0]    cfg_vtrip;
  logic [2:0]    cfg_otrip;
  logic          cfg_fast;
  logic          evt_clr;
  logic          irq_ack;
  logic          bo_pgood;
  logic          bo_ena;
  logic [2:0]    bo_vtrip;
  logic [2:0]    bo_otrip;
  logic          bo_force_short;
  logic          armed;
  logic          irq;
  logic [EW-1:0] evt_cnt;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  brownout_ctrl #(.SETTLE_CYCLES(SC), .EVT_W(EW)) dut (
    .osc_ck         (osc_ck),
    .rsb            (rsb),
    .cfg_ena        (cfg_ena),
    .cfg_vtrip      (cfg_vtrip),
    .cfg_otrip      (cfg_otrip),
    .cfg_fast       (cfg_fast),
    .evt_clr        (evt_clr),
    .irq_ack        (irq_ack),
    .bo_pgood       (bo_pgood),
    .bo_ena         (bo_ena),
    .bo_vtrip       (bo_vtrip),
    .bo_otrip       (bo_otrip),
    .bo_force_short (bo_force_short),
    .armed          (armed),
    .irq            (irq),
    .evt_cnt        (evt_cnt)
  );

  always #5 osc_ck = ~osc_ck;

  // Edge counter used to time-stamp expectations.
  always @(posedge osc_ck) cyc <= cyc + 1;

  function automatic logic [7:0] dut_val(input int sig);
    case (sig)
      S_ENA:   return {7'd0, bo_ena};
      S_VTRIP: return {5'd0, bo_vtrip};
      S_OTRIP: return {5'd0, bo_otrip};
      S_FAST:  return {7'd0, bo_force_short};
      S_ARMED: return {7'd0, armed};
      S_IRQ:   return {7'd0, irq};
      S_EVT:   return {6'd0, evt_cnt};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input int sig, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  // Monitor: compare every expectation due at this edge; flag any overdue one.
  always @(negedge osc_ck) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        check(sbq[i].name, dut_val(sbq[i].sig), sbq[i].val);
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        check({sbq[i].name, "_overdue"}, 8'hff, sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge osc_ck);
    #1;
  endtask

  // One brownout of len cycles from ARMED; optional ack/clr on the event edge.
  task automatic pulse(input int len, input logic [7:0] exp_evt, input bit ack, input bit clr);
    int c;
    c = cyc;
    bo_pgood = 1'b0;
    expect_at(c + 3, S_IRQ,   8'd1,    "pulse_irq");
    expect_at(c + 3, S_EVT,   exp_evt, "pulse_evt");
    expect_at(c + 3, S_ARMED, 8'd0,    "pulse_armed_lo");
    tick(2);
    irq_ack = ack;
    evt_clr = clr;
    tick(1);
    irq_ack = 1'b0;
    evt_clr = 1'b0;
    tick(len - 3);
    bo_pgood = 1'b1;
    expect_at(c + len + 3, S_ARMED, 8'd1, "pulse_armed_hi");
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    rsb = 1'b0; cfg_ena = 1'b0; cfg_vtrip = 3'b000; cfg_otrip = 3'b000;
    cfg_fast = 1'b0; evt_clr = 1'b0; irq_ack = 1'b0; bo_pgood = 1'b1;

    // Reset values while rsb is held low.
    tick(2);
    for (int s = 0; s < 7; s++) expect_at(cyc + 1, s, 8'd0, "rst_val");
    tick(1);

    // Release reset; thresholds track cfg while OFF.
    rsb = 1'b1; cfg_vtrip = 3'b010; cfg_otrip = 3'b001; cfg_fast = 1'b1;
    c = cyc;
    expect_at(c + 1, S_VTRIP, 8'd2, "off_vtrip");
    expect_at(c + 1, S_OTRIP, 8'd1, "off_otrip");
    expect_at(c + 1, S_FAST,  8'd1, "fast_reg");
    expect_at(c + 1, S_ENA,   8'd0, "off_ena");
    tick(3);

    // Enable with good supply: armed exactly SC edges after bo_ena.
    c = cyc;
    cfg_ena = 1'b1;
    expect_at(c + 1,      S_ENA,   8'd1, "en_bo_ena");
    expect_at(c + 1,      S_ARMED, 8'd0, "en_armed_early");
    expect_at(c + SC,     S_ARMED, 8'd0, "en_armed_lastlow");
    expect_at(c + SC + 1, S_ARMED, 8'd1, "en_armed");
    expect_at(c + SC + 1, S_IRQ,   8'd0, "en_irq");
    expect_at(c + SC + 1, S_EVT,   8'd0, "en_evt");
    tick(SC + 2);

    // Single brownout of 10 cycles, then ack.
    c = cyc;
    bo_pgood = 1'b0;
    expect_at(c + 2, S_IRQ,   8'd0, "bo_irq_early");
    expect_at(c + 2, S_ARMED, 8'd1, "bo_armed_early");
    expect_at(c + 3, S_IRQ,   8'd1, "bo_irq");
    expect_at(c + 3, S_EVT,   8'd1, "bo_evt");
    expect_at(c + 3, S_ARMED, 8'd0, "bo_armed_lo");
    tick(10);
    bo_pgood = 1'b1;
    expect_at(c + 12, S_ARMED, 8'd0, "bo_rearm_early");
    expect_at(c + 13, S_ARMED, 8'd1, "bo_rearm");
    expect_at(c + 14, S_IRQ,   8'd1, "bo_irq_held");
    tick(4);
    irq_ack = 1'b1;
    expect_at(cyc + 1, S_IRQ, 8'd0, "ack_clear");
    tick(1);
    irq_ack = 1'b0;
    tick(1);

    // Retune 010->101 with a 5-cycle brownout inside the settle window.
    c = cyc;
    cfg_vtrip = 3'b101;
    expect_at(c + 1,      S_VTRIP, 8'd5, "rt_vtrip");
    expect_at(c + 1,      S_ARMED, 8'd0, "rt_armed_lo");
    expect_at(c + 20,     S_IRQ,   8'd0, "rt_masked_irq");
    expect_at(c + 20,     S_EVT,   8'd1, "rt_masked_evt");
    expect_at(c + SC,     S_ARMED, 8'd0, "rt_armed_lastlow");
    expect_at(c + SC + 1, S_ARMED, 8'd1, "rt_armed");
    expect_at(c + SC + 1, S_EVT,   8'd1, "rt_evt_after");
    tick(10);
    bo_pgood = 1'b0;
    tick(5);
    bo_pgood = 1'b1;
    tick(SC + 2 - 15);

    // Retune with power bad when the counter drains: held until pg_s recovers.
    c = cyc;
    cfg_vtrip = 3'b010;
    expect_at(c + 1,  S_VTRIP, 8'd2, "hold_vtrip");
    expect_at(c + 65, S_ARMED, 8'd0, "hold_cnt0_lo");
    expect_at(c + 72, S_ARMED, 8'd0, "hold_still_lo");
    expect_at(c + 73, S_ARMED, 8'd1, "hold_armed");
    expect_at(c + 73, S_IRQ,   8'd0, "hold_irq");
    expect_at(c + 73, S_EVT,   8'd1, "hold_evt");
    tick(60);
    bo_pgood = 1'b0;
    tick(10);
    bo_pgood = 1'b1;
    tick(4);

    // Ack colliding with a new event: set wins.
    pulse(8, 8'd2, 1'b1, 1'b0);
    // Saturation at 3 with EVT_W=2, then clear coincident with 6th event.
    pulse(6, 8'd3, 1'b0, 1'b0);
    pulse(6, 8'd3, 1'b0, 1'b0);
    pulse(6, 8'd3, 1'b0, 1'b0);
    pulse(6, 8'd1, 1'b0, 1'b1);
    irq_ack = 1'b1;
    expect_at(cyc + 1, S_IRQ, 8'd0, "ack2_clear");
    tick(1);
    irq_ack = 1'b0;

    // Disable while TRIPPED: bo_ena drops next edge, count and irq retained.
    c = cyc;
    bo_pgood = 1'b0;
    tick(5);
    cfg_ena = 1'b0;
    expect_at(cyc + 1, S_ENA,   8'd0, "dis_ena");
    expect_at(cyc + 1, S_EVT,   8'd2, "dis_evt");
    expect_at(cyc + 1, S_IRQ,   8'd1, "dis_irq");
    expect_at(cyc + 1, S_ARMED, 8'd0, "dis_armed");
    tick(1);
    bo_pgood = 1'b1;
    tick(4);
    cfg_otrip = 3'b110; cfg_fast = 1'b0;
    expect_at(cyc + 1, S_OTRIP, 8'd6, "off_otrip2");
    expect_at(cyc + 1, S_FAST,  8'd0, "fast_reg0");
    tick(1);

    // Re-enable, then retune and reset asynchronously mid-RETUNE.
    c = cyc;
    cfg_ena = 1'b1;
    expect_at(c + 1,      S_ENA,   8'd1, "re_en_ena");
    expect_at(c + SC + 1, S_ARMED, 8'd1, "re_en_armed");
    tick(SC + 2);
    cfg_otrip = 3'b011;
    expect_at(cyc + 1, S_OTRIP, 8'd3, "rt2_otrip");
    expect_at(cyc + 1, S_ARMED, 8'd0, "rt2_armed_lo");
    tick(10);
    #2;
    rsb = 1'b0;
    #1;
    for (int s = 0; s < 7; s++) check("async_rst", dut_val(s), 8'd0);
    #2;
    rsb = 1'b1;
    tick(2);
    check("sb_drain", 8'(sbq.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule : tb_brownout_ctrl
